// File: rtl/vram_fill_ctrl.sv
// Rectangle-fill engine sharing a registered VRAM write port with CPU writes (CPU has priority).
// Optional macro FILL_CLIP_EN suppresses writes for pixels outside H_RES x V_RES.
module vram_fill_ctrl #(
  parameter int unsigned H_RES = 200,
  parameter int unsigned V_RES = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we_i,
  input  logic [14:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        fill_start_i,
  input  logic [7:0]  fill_x_i,
  input  logic [7:0]  fill_y_i,
  input  logic [7:0]  fill_w_i,
  input  logic [7:0]  fill_h_i,
  input  logic [7:0]  fill_color_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        v_we_o,
  output logic [14:0] v_addr_o,
  output logic [7:0]  v_data_o
);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_x, r_y, r_w, r_h, r_color;
  logic [7:0]  w_x_nxt, w_y_nxt, w_w_nxt, w_h_nxt, w_color_nxt;
  logic [7:0]  r_cx, r_cy, w_cx_nxt, w_cy_nxt;
  logic        r_we, r_done, w_we_nxt, w_done_nxt;
  logic [14:0] r_addr, w_addr_nxt;
  logic [7:0]  r_data, w_data_nxt;

  logic [8:0]  w_sum_x, w_sum_y;
  logic [14:0] w_fill_addr;
  logic        w_in_bounds, w_pix_ok, w_last;

  assign w_sum_x     = {1'b0, r_x} + {1'b0, r_cx};
  assign w_sum_y     = {1'b0, r_y} + {1'b0, r_cy};
  // Address formed at 16 bits, then the top bit is dropped.
  assign w_fill_addr = 15'(16'(w_sum_y) * 16'(H_RES) + 16'(w_sum_x));
  assign w_in_bounds = (32'(w_sum_x) < H_RES) && (32'(w_sum_y) < V_RES);
  assign w_last      = (r_cx == r_w - 8'd1) && (r_cy == r_h - 8'd1);

`ifdef FILL_CLIP_EN
  assign w_pix_ok = w_in_bounds;
`else
  logic w_unused_bounds;
  assign w_unused_bounds = w_in_bounds;
  assign w_pix_ok        = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_w_nxt     = r_w;
    w_h_nxt     = r_h;
    w_color_nxt = r_color;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;

    if (cpu_we_i) begin
      w_we_nxt   = 1'b1;
      w_addr_nxt = cpu_addr_i;
      w_data_nxt = cpu_data_i;
    end

    unique case (r_state)
      StIdle: begin
        if (fill_start_i) begin
          w_x_nxt     = fill_x_i;
          w_y_nxt     = fill_y_i;
          w_w_nxt     = fill_w_i;
          w_h_nxt     = fill_h_i;
          w_color_nxt = fill_color_i;
          w_cx_nxt    = 8'd0;
          w_cy_nxt    = 8'd0;
          if (fill_w_i == 8'd0 || fill_h_i == 8'd0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = StFill;
          end
        end
      end
      StFill: begin
        // A CPU write steals the cycle; counters hold.
        if (!cpu_we_i) begin
          if (w_pix_ok) begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = w_fill_addr;
            w_data_nxt = r_color;
          end
          if (r_cx == r_w - 8'd1) begin
            w_cx_nxt = 8'd0;
            w_cy_nxt = r_cy + 8'd1;
          end else begin
            w_cx_nxt = r_cx + 8'd1;
          end
          if (w_last) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_x     <= 8'd0;
      r_y     <= 8'd0;
      r_w     <= 8'd0;
      r_h     <= 8'd0;
      r_color <= 8'd0;
      r_cx    <= 8'd0;
      r_cy    <= 8'd0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= 15'd0;
      r_data  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_w     <= w_w_nxt;
      r_h     <= w_h_nxt;
      r_color <= w_color_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      r_we    <= w_we_nxt;
      r_done  <= w_done_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign busy_o   = (r_state == StFill);
  assign done_o   = r_done;
  assign v_we_o   = r_we;
  assign v_addr_o = r_addr;
  assign v_data_o = r_data;

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Directed self-checking bench for vram_fill_ctrl; define FILL_CLIP_EN to include the clip case.
module tb_vram_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we_i;
  logic [14:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic        fill_start_i;
  logic [7:0]  fill_x_i, fill_y_i, fill_w_i, fill_h_i, fill_color_i;
  logic        busy_o, done_o, v_we_o;
  logic [14:0] v_addr_o;
  logic [7:0]  v_data_o;

  int n_checks = 0;
  int n_errors = 0;

  vram_fill_ctrl #(.H_RES(200), .V_RES(150)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .fill_start_i (fill_start_i),
    .fill_x_i     (fill_x_i),
    .fill_y_i     (fill_y_i),
    .fill_w_i     (fill_w_i),
    .fill_h_i     (fill_h_i),
    .fill_color_i (fill_color_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .v_we_o       (v_we_o),
    .v_addr_o     (v_addr_o),
    .v_data_o     (v_data_o)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // Checks the full output bundle in one go.
  task automatic chk_out(input string tag, input logic busy, input logic done, input logic we,
                         input logic [14:0] addr, input logic [7:0] data);
    chk({tag, ".busy"}, 32'(busy_o), 32'(busy));
    chk({tag, ".done"}, 32'(done_o), 32'(done));
    chk({tag, ".we"}, 32'(v_we_o), 32'(we));
    if (we) begin
      chk({tag, ".addr"}, 32'(v_addr_o), 32'(addr));
      chk({tag, ".data"}, 32'(v_data_o), 32'(data));
    end
  endtask

  task automatic start_fill(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                            input logic [7:0] h, input logic [7:0] c);
    fill_x_i = x; fill_y_i = y; fill_w_i = w; fill_h_i = h; fill_color_i = c;
    fill_start_i = 1'b1;
    tick();
    fill_start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    fill_start_i = 1'b0;
    fill_x_i = '0; fill_y_i = '0; fill_w_i = '0; fill_h_i = '0; fill_color_i = '0;
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
    chk("reset.addr", 32'(v_addr_o), 32'd0);
    chk("reset.data", 32'(v_data_o), 32'd0);
    rst = 1'b0;
    tick();

    // CPU write while idle, then hold behaviour
    cpu_we_i = 1'b1; cpu_addr_i = 15'h1234; cpu_data_i = 8'h5A;
    tick();
    cpu_we_i = 1'b0;
    chk_out("cpu_idle", 1'b0, 1'b0, 1'b1, 15'h1234, 8'h5A);
    tick();
    chk_out("cpu_idle_off", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
    chk("cpu_idle_hold.addr", 32'(v_addr_o), 32'h1234);
    chk("cpu_idle_hold.data", 32'(v_data_o), 32'h5A);

    // Basic 2x2 fill
    start_fill(8'd10, 8'd5, 8'd2, 8'd2, 8'hE0);
    chk_out("fill_c1", 1'b1, 1'b0, 1'b0, 15'd0, 8'd0);
    tick(); chk_out("fill_w1", 1'b1, 1'b0, 1'b1, 15'd1010, 8'hE0);
    tick(); chk_out("fill_w2", 1'b1, 1'b0, 1'b1, 15'd1011, 8'hE0);
    tick(); chk_out("fill_w3", 1'b1, 1'b0, 1'b1, 15'd1210, 8'hE0);
    tick(); chk_out("fill_w4", 1'b0, 1'b1, 1'b1, 15'd1211, 8'hE0);
    tick(); chk_out("fill_end", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
    chk("fill_end_hold.addr", 32'(v_addr_o), 32'd1211);

    // CPU contention on the 2nd FILL cycle
    start_fill(8'd10, 8'd5, 8'd2, 8'd2, 8'hE0);
    tick(); chk_out("cont_w1", 1'b1, 1'b0, 1'b1, 15'd1010, 8'hE0);
    cpu_we_i = 1'b1; cpu_addr_i = 15'h0042; cpu_data_i = 8'h1C;
    tick();
    cpu_we_i = 1'b0;
    chk_out("cont_cpu", 1'b1, 1'b0, 1'b1, 15'h0042, 8'h1C);
    tick(); chk_out("cont_w2", 1'b1, 1'b0, 1'b1, 15'd1011, 8'hE0);
    tick(); chk_out("cont_w3", 1'b1, 1'b0, 1'b1, 15'd1210, 8'hE0);
    tick(); chk_out("cont_w4", 1'b0, 1'b1, 1'b1, 15'd1211, 8'hE0);
    tick(); chk_out("cont_end", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);

    // Degenerate fill
    start_fill(8'd3, 8'd3, 8'd0, 8'd7, 8'hFF);
    chk_out("degen_done", 1'b0, 1'b1, 1'b0, 15'd0, 8'd0);
    tick(); chk_out("degen_after", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);

    // Second start while busy is ignored
    start_fill(8'd10, 8'd5, 8'd2, 8'd2, 8'hE0);
    fill_x_i = 8'd0; fill_y_i = 8'd0; fill_w_i = 8'd1; fill_h_i = 8'd1; fill_color_i = 8'h03;
    fill_start_i = 1'b1;
    tick();
    fill_start_i = 1'b0;
    chk_out("restart_w1", 1'b1, 1'b0, 1'b1, 15'd1010, 8'hE0);
    tick(); chk_out("restart_w2", 1'b1, 1'b0, 1'b1, 15'd1011, 8'hE0);
    tick(); chk_out("restart_w3", 1'b1, 1'b0, 1'b1, 15'd1210, 8'hE0);
    tick(); chk_out("restart_w4", 1'b0, 1'b1, 1'b1, 15'd1211, 8'hE0);
    tick(); chk_out("restart_end", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);

    // Reset during a 10x10 fill after the 3rd write
    start_fill(8'd0, 8'd0, 8'd10, 8'd10, 8'h55);
    tick(); chk_out("rst_w1", 1'b1, 1'b0, 1'b1, 15'd0, 8'h55);
    tick(); chk_out("rst_w2", 1'b1, 1'b0, 1'b1, 15'd1, 8'h55);
    tick(); chk_out("rst_w3", 1'b1, 1'b0, 1'b1, 15'd2, 8'h55);
    rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
    chk("rst_async.addr", 32'(v_addr_o), 32'd0);
    chk("rst_async.data", 32'(v_data_o), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("rst_quiet", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
    end

`ifdef FILL_CLIP_EN
    // Clipping at the bottom-right corner
    start_fill(8'd198, 8'd149, 8'd4, 8'd2, 8'hAA);
    chk_out("clip_c1", 1'b1, 1'b0, 1'b0, 15'd0, 8'd0);
    tick(); chk_out("clip_w1", 1'b1, 1'b0, 1'b1, 15'd29998, 8'hAA);
    tick(); chk_out("clip_w2", 1'b1, 1'b0, 1'b1, 15'd29999, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("clip_skip", 1'b1, 1'b0, 1'b0, 15'd0, 8'd0);
    end
    tick(); chk_out("clip_done", 1'b0, 1'b1, 1'b0, 15'd0, 8'd0);
    tick(); chk_out("clip_end", 1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
